// File: rtl/vx_tensor_wb_serializer.sv
// Tensor writeback serializer: pairs result tiles with uop metadata and emits each tile as two lane beats.
// Optional macro TENSOR_WB_PERF_EN adds a wrapping stall-cycle counter output (perf_stall_cycles).

module vx_tensor_wb_octet_mux #(
   parameter int DATA_W = 32
) (
   input  logic [16*DATA_W-1:0] tile,
   input  logic                 beat,
   output logic [4*DATA_W-1:0]  lo,
   output logic [4*DATA_W-1:0]  hi
);
   // Lane j takes row j%2 (lo) or 2+j%2 (hi), column beat + 2*(j/2).
   for (genvar j = 0; j < 4; j++) begin : g_lane
      localparam int R = j % 2;
      localparam int C = 2 * (j / 2);
      assign lo[j*DATA_W +: DATA_W] = beat ? tile[(4*R + C + 1)*DATA_W +: DATA_W]
                                           : tile[(4*R + C)*DATA_W +: DATA_W];
      assign hi[j*DATA_W +: DATA_W] = beat ? tile[(4*(R+2) + C + 1)*DATA_W +: DATA_W]
                                           : tile[(4*(R+2) + C)*DATA_W +: DATA_W];
   end
endmodule

module vx_tensor_wb_serializer #(
   parameter int NUM_OCTETS = 1,
   parameter int DATA_W     = 32,
   parameter int META_W     = 64,
   parameter int TILE_DEPTH = 2,
   parameter int META_DEPTH = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           tile_valid,
   output logic                           tile_ready,
   input  logic [NUM_OCTETS*16*DATA_W-1:0] tile_data,
   input  logic                           meta_valid,
   output logic                           meta_ready,
   input  logic [META_W-1:0]              meta_data,
   output logic                           wb_valid,
   input  logic                           wb_ready,
   output logic [8*NUM_OCTETS*DATA_W-1:0] wb_data,
   output logic [META_W-1:0]              wb_meta,
`ifdef TENSOR_WB_PERF_EN
   output logic [31:0]                    perf_stall_cycles,
`endif
   output logic                           wb_beat
);
   localparam int TW  = NUM_OCTETS*16*DATA_W;
   localparam int LO  = 4*NUM_OCTETS;
   localparam int TPW = (TILE_DEPTH > 1) ? $clog2(TILE_DEPTH) : 1;
   localparam int MPW = (META_DEPTH > 1) ? $clog2(META_DEPTH) : 1;
   localparam int TCW = $clog2(TILE_DEPTH + 1);
   localparam int MCW = $clog2(META_DEPTH + 1);

   typedef enum logic {BEAT0 = 1'b0, BEAT1 = 1'b1} beat_t;

   logic [TW-1:0]     tile_mem [TILE_DEPTH];
   logic [META_W-1:0] meta_mem [META_DEPTH];
   logic [TPW-1:0]    tile_wr, tile_rd;
   logic [MPW-1:0]    meta_wr, meta_rd;
   logic [TCW-1:0]    tile_count;
   logic [MCW-1:0]    meta_count;
   beat_t             state;

   logic tile_push, meta_push, fire, pop;

   assign tile_ready = tile_count < TCW'(TILE_DEPTH);
   assign meta_ready = meta_count < MCW'(META_DEPTH);
   assign wb_valid   = (tile_count != '0) && (meta_count != '0);
   assign tile_push  = tile_valid && tile_ready;
   assign meta_push  = meta_valid && meta_ready;
   assign fire       = wb_valid && wb_ready;
   assign pop        = fire && (state == BEAT1);

   // Storage is never reset; only the pointers and counts gate visibility.
   always_ff @(posedge clk) begin
      if (tile_push) tile_mem[tile_wr] <= tile_data;
      if (meta_push) meta_mem[meta_wr] <= meta_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tile_wr    <= '0;
         tile_rd    <= '0;
         tile_count <= '0;
         meta_wr    <= '0;
         meta_rd    <= '0;
         meta_count <= '0;
      end else begin
         if (tile_push) tile_wr <= (tile_wr == TPW'(TILE_DEPTH-1)) ? '0 : tile_wr + 1'b1;
         if (meta_push) meta_wr <= (meta_wr == MPW'(META_DEPTH-1)) ? '0 : meta_wr + 1'b1;
         if (pop) begin
            tile_rd <= (tile_rd == TPW'(TILE_DEPTH-1)) ? '0 : tile_rd + 1'b1;
            meta_rd <= (meta_rd == MPW'(META_DEPTH-1)) ? '0 : meta_rd + 1'b1;
         end
         if (tile_push && !pop)      tile_count <= tile_count + 1'b1;
         else if (!tile_push && pop) tile_count <= tile_count - 1'b1;
         if (meta_push && !pop)      meta_count <= meta_count + 1'b1;
         else if (!meta_push && pop) meta_count <= meta_count - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= BEAT0;
         wb_beat <= 1'b0;
      end else if (fire) begin
         case (state)
            BEAT0:   begin state <= BEAT1; wb_beat <= 1'b1; end
            default: begin state <= BEAT0; wb_beat <= 1'b0; end
         endcase
      end
   end

`ifdef TENSOR_WB_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                     perf_stall_cycles <= '0;
      else if (wb_valid && !wb_ready) perf_stall_cycles <= perf_stall_cycles + 32'd1;
   end
`endif

   logic [TW-1:0] tile_head;
   assign tile_head = tile_mem[tile_rd];
   assign wb_meta   = meta_mem[meta_rd];

   for (genvar i = 0; i < NUM_OCTETS; i++) begin : g_oct
      logic [4*DATA_W-1:0] lo, hi;
      vx_tensor_wb_octet_mux #(.DATA_W(DATA_W)) u_mux (
         .tile (tile_head[i*16*DATA_W +: 16*DATA_W]),
         .beat (wb_beat),
         .lo   (lo),
         .hi   (hi)
      );
      assign wb_data[(4*i)*DATA_W +: 4*DATA_W]    = lo;
      assign wb_data[(LO+4*i)*DATA_W +: 4*DATA_W] = hi;
   end
endmodule

// File: tb/tb_vx_tensor_wb_serializer.sv
// Self-checking bench for vx_tensor_wb_serializer: queue model of tiles/metadata checked every cycle,
// plus directed scenario tasks with inline checks.
module tb_vx_tensor_wb_serializer;
   localparam int N  = 1;
   localparam int DW = 32;
   localparam int MW = 64;
   localparam int TW = N*16*DW;
   localparam int WW = 8*N*DW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          tile_valid = 1'b0, meta_valid = 1'b0, wb_ready = 1'b0;
   logic [TW-1:0] tile_data = '0;
   logic [MW-1:0] meta_data = '0;
   logic          tile_ready, meta_ready, wb_valid, wb_beat;
   logic [WW-1:0] wb_data;
   logic [MW-1:0] wb_meta;
`ifdef TENSOR_WB_PERF_EN
   logic [31:0]   perf_stall_cycles;
`endif

   int total = 0;
   int bad   = 0;
   int nbeats = 0;

   vx_tensor_wb_serializer dut (
      .clk(clk), .reset(reset),
      .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_data(tile_data),
      .meta_valid(meta_valid), .meta_ready(meta_ready), .meta_data(meta_data),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_meta(wb_meta),
`ifdef TENSOR_WB_PERF_EN
      .perf_stall_cycles(perf_stall_cycles),
`endif
      .wb_beat(wb_beat)
   );

   always #5 clk = ~clk;

   // Scoreboard: accepted tiles and metadata, consumed two beats per pair.
   logic [TW-1:0] tq[$];
   logic [MW-1:0] mq[$];
   logic          mbeat = 1'b0;

   function automatic logic [WW-1:0] exp_beat(input logic [TW-1:0] t, input logic b);
      logic [WW-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++)
         for (int r = 0; r < 4; r++)
            for (int cc = 0; cc < 2; cc++) begin
               int c, lane;
               c    = int'(b) + 2*cc;
               lane = ((r < 2) ? 0 : 4*N) + 4*i + 2*cc + (r % 2);
               v[lane*DW +: DW] = t[(16*i + 4*r + c)*DW +: DW];
            end
      return v;
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         tq.delete(); mq.delete(); mbeat = 1'b0;
      end else begin
         logic ev;
         ev = (tq.size() > 0) && (mq.size() > 0);
         total++;
         if (tile_ready !== (tq.size() < 2)) begin
            bad++; $display("FAIL tile_ready: got %b want %b", tile_ready, tq.size() < 2);
         end
         total++;
         if (meta_ready !== (mq.size() < 16)) begin
            bad++; $display("FAIL meta_ready: got %b want %b", meta_ready, mq.size() < 16);
         end
         total++;
         if (wb_valid !== ev) begin
            bad++; $display("FAIL wb_valid: got %b want %b", wb_valid, ev);
         end
         if (ev && wb_valid) begin
            total++;
            if (wb_beat !== mbeat || wb_meta !== mq[0] || wb_data !== exp_beat(tq[0], mbeat)) begin
               bad++;
               $display("FAIL beat: got beat=%b meta=%h data=%h want beat=%b meta=%h data=%h",
                        wb_beat, wb_meta, wb_data, mbeat, mq[0], exp_beat(tq[0], mbeat));
            end
            if (wb_ready) begin
               nbeats++;
               if (mbeat) begin void'(tq.pop_front()); void'(mq.pop_front()); end
               mbeat = ~mbeat;
            end
         end
         if (tile_valid && tile_ready) tq.push_back(tile_data);
         if (meta_valid && meta_ready) mq.push_back(meta_data);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      tile_valid = 0; meta_valid = 0; wb_ready = 0;
      reset = 1; tick(); reset = 0; tick();
   endtask

   function automatic logic [TW-1:0] rand_tile();
      logic [TW-1:0] v;
      for (int w = 0; w < TW/32; w++) v[w*32 +: 32] = $urandom();
      return v;
   endfunction

   task automatic test_reset();
      #3;
      total++;
      if (tile_ready !== 1'b1 || meta_ready !== 1'b1 || wb_valid !== 1'b0 || wb_beat !== 1'b0) begin
         bad++; $display("FAIL reset_state: got tr=%b mr=%b v=%b b=%b want 1 1 0 0",
                         tile_ready, meta_ready, wb_valid, wb_beat);
      end
      tick(); reset = 0; tick();
   endtask

   task automatic test_basic();
      int e0[8] = '{0, 16, 2, 18, 32, 48, 34, 50};
      int e1[8] = '{1, 17, 3, 19, 33, 49, 35, 51};
      do_reset();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) tile_data[(4*r+c)*DW +: DW] = DW'(16*r + c);
      meta_data = 64'hA5; tile_valid = 1; meta_valid = 1; wb_ready = 1;
      tick();
      tile_valid = 0; meta_valid = 0;
      total++;
      if (wb_valid !== 1'b1 || wb_beat !== 1'b0 || wb_meta !== 64'hA5) begin
         bad++; $display("FAIL basic_beat0_hdr: got v=%b b=%b m=%h want 1 0 a5", wb_valid, wb_beat, wb_meta);
      end
      for (int k = 0; k < 8; k++) begin
         total++;
         if (wb_data[k*DW +: DW] !== DW'(e0[k])) begin
            bad++; $display("FAIL basic_beat0_lane%0d: got %0d want %0d", k, wb_data[k*DW +: DW], e0[k]);
         end
      end
      tick();
      total++;
      if (wb_valid !== 1'b1 || wb_beat !== 1'b1 || wb_meta !== 64'hA5) begin
         bad++; $display("FAIL basic_beat1_hdr: got v=%b b=%b m=%h want 1 1 a5", wb_valid, wb_beat, wb_meta);
      end
      for (int k = 0; k < 8; k++) begin
         total++;
         if (wb_data[k*DW +: DW] !== DW'(e1[k])) begin
            bad++; $display("FAIL basic_beat1_lane%0d: got %0d want %0d", k, wb_data[k*DW +: DW], e1[k]);
         end
      end
      tick();
      total++;
      if (wb_valid !== 1'b0 || tile_ready !== 1'b1 || wb_beat !== 1'b0) begin
         bad++; $display("FAIL basic_empty: got v=%b tr=%b b=%b want 0 1 0", wb_valid, tile_ready, wb_beat);
      end
   endtask

   task automatic test_no_meta();
      int start;
      do_reset();
      wb_ready = 1;
      for (int t = 0; t < 2; t++) begin tile_data = rand_tile(); tile_valid = 1; tick(); end
      tile_valid = 0;
      tick();
      total++;
      if (tile_ready !== 1'b0 || wb_valid !== 1'b0) begin
         bad++; $display("FAIL nometa_hold: got tr=%b v=%b want 0 0", tile_ready, wb_valid);
      end
      start = nbeats;
      for (int m = 0; m < 2; m++) begin meta_data = 64'h100 + 64'(m); meta_valid = 1; tick(); end
      meta_valid = 0;
      for (int k = 0; k < 20 && wb_valid; k++) tick();
      total++;
      if (nbeats - start !== 4 || tile_ready !== 1'b1 || wb_valid !== 1'b0) begin
         bad++; $display("FAIL nometa_drain: got beats=%0d tr=%b v=%b want 4 1 0", nbeats - start, tile_ready, wb_valid);
      end
   endtask

   task automatic test_stall();
      logic [WW-1:0] d0;
      logic [MW-1:0] m0;
      do_reset();
      tile_data = rand_tile(); meta_data = 64'hDEAD_BEEF_0000_0037;
      tile_valid = 1; meta_valid = 1; wb_ready = 1;
      tick();
      tile_valid = 0; meta_valid = 0;
      tick();
      wb_ready = 0;
      #1;
      d0 = exp_beat(tile_data, 1'b1); m0 = meta_data;
      for (int k = 0; k < 5; k++) begin
         tick();
         total++;
         if (wb_valid !== 1'b1 || wb_beat !== 1'b1 || wb_data !== d0 || wb_meta !== m0 || tile_ready !== 1'b1) begin
            bad++; $display("FAIL stall_stable%0d: got v=%b b=%b m=%h want 1 1 %h", k, wb_valid, wb_beat, wb_meta, m0);
         end
      end
`ifdef TENSOR_WB_PERF_EN
      total++;
      if (perf_stall_cycles !== 32'd5) begin
         bad++; $display("FAIL perf_stall: got %0d want 5", perf_stall_cycles);
      end
`endif
      wb_ready = 1; tick();
      total++;
      if (wb_valid !== 1'b0 || wb_beat !== 1'b0) begin
         bad++; $display("FAIL stall_release: got v=%b b=%b want 0 0", wb_valid, wb_beat);
      end
   endtask

   task automatic test_meta_full();
      do_reset();
      for (int m = 0; m < 15; m++) begin meta_data = 64'h200 + 64'(m); meta_valid = 1; tick(); end
      meta_valid = 0;
      tile_data = rand_tile(); tile_valid = 1; tick(); tile_valid = 0;
      wb_ready = 1; tick();              // beat0 fired; now in BEAT1
      meta_data = 64'h2FF; meta_valid = 1;
      tick();                            // BEAT1 pop and meta push in the same cycle
      meta_valid = 0; wb_ready = 0;
      total++;
      if (meta_ready !== 1'b1 || mq.size() !== 15) begin
         bad++; $display("FAIL meta_netzero: got mr=%b size=%0d want 1 15", meta_ready, mq.size());
      end
      meta_data = 64'h300; meta_valid = 1; tick(); meta_valid = 0;
      total++;
      if (meta_ready !== 1'b0) begin
         bad++; $display("FAIL meta_full: got mr=%b want 0", meta_ready);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int t = 0; t < 2; t++) begin
         tile_data = rand_tile(); meta_data = 64'h400 + 64'(t);
         tile_valid = 1; meta_valid = 1; tick();
      end
      tile_valid = 0; meta_valid = 0; wb_ready = 1;
      tick();
      wb_ready = 0;
      total++;
      if (wb_beat !== 1'b1 || tile_ready !== 1'b0) begin
         bad++; $display("FAIL rmid_setup: got b=%b tr=%b want 1 0", wb_beat, tile_ready);
      end
      #2 reset = 1;
      #1;
      total++;
      if (wb_valid !== 1'b0 || wb_beat !== 1'b0 || tile_ready !== 1'b1 || meta_ready !== 1'b1) begin
         bad++; $display("FAIL rmid_async: got v=%b b=%b tr=%b mr=%b want 0 0 1 1", wb_valid, wb_beat, tile_ready, meta_ready);
      end
      tick(); reset = 0; wb_ready = 1;
      for (int k = 0; k < 5; k++) begin
         tick();
         total++;
         if (wb_valid !== 1'b0) begin
            bad++; $display("FAIL rmid_stale%0d: got v=%b want 0", k, wb_valid);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int k = 0; k < 60; k++) begin
         tile_data  = rand_tile();
         meta_data  = {32'h0, $urandom()};
         tile_valid = ($urandom_range(0, 3) != 0);
         meta_valid = ($urandom_range(0, 2) != 0);
         wb_ready   = ($urandom_range(0, 3) != 0);
         tick();
      end
      wb_ready = 1;
      for (int k = 0; k < 200 && (tq.size() > 0 || mq.size() > 0); k++) begin
         tile_data  = rand_tile();
         tile_valid = (mq.size() > tq.size());
         meta_valid = (tq.size() > mq.size());
         tick();
      end
      tile_valid = 0; meta_valid = 0;
      tick();
      total++;
      if (wb_valid !== 1'b0 || tq.size() != 0 || mq.size() != 0) begin
         bad++; $display("FAIL b2b_drain: got v=%b tiles=%0d metas=%0d want 0 0 0", wb_valid, tq.size(), mq.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_no_meta();
      test_stall();
      test_meta_full();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
